// File: rtl/dcache_rdq_pkg.sv
// Purpose: shared types and defaults for the dcache data-array read request queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcache_rdq_pkg;

    localparam int ADDR_W = 12;

    // Default-width view of one queued request: data-array row plus slot-0 tag.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              valid_0;
    } rdq_entry_t;

    localparam int DEFAULT_STARVE_LIMIT = 63;

endpackage

// File: rtl/dcache_rdq_starve_wdog.sv
// Purpose: flags a queue head that keeps losing data-array read arbitration.
// Latency: starved rises at the edge that completes STARVE_LIMIT lost cycles, falls at the edge after a grant/flush/empty.
// Backpressure: none; it only observes the deq handshake.
module dcache_rdq_starve_wdog
    import dcache_rdq_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    input  logic deq_valid,
    input  logic deq_ready,
    output logic starved
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] lost_cnt;
    logic [CNT_W-1:0] lost_cnt_nxt;

    // Count consecutive lost cycles, saturating at the limit; any grant, flush or empty restarts.
    always_comb begin
        lost_cnt_nxt = lost_cnt;
        if (flush || !deq_valid || deq_ready) begin
            lost_cnt_nxt = '0;
        end else if (lost_cnt != LIMIT) begin
            lost_cnt_nxt = lost_cnt + CNT_W'(1);
        end
    end

    // Flag is registered from the next count so it tracks lost_cnt == LIMIT without a glitchy compare on the output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lost_cnt <= '0;
            starved  <= 1'b0;
        end else begin
            lost_cnt <= lost_cnt_nxt;
            starved  <= (lost_cnt_nxt == LIMIT);
        end
    end

endmodule

// File: rtl/dcache_data_read_req_queue.sv
// Purpose: FIFO of low-priority (probe/writeback) data-array read requests feeding the arbiter's lowest-priority port.
// Latency: 1 cycle enq-to-deq, no combinational flow-through; optional starvation watchdog under DCACHE_RDQ_STARVE_WATCHDOG_EN.
// Backpressure: enq_ready drops when full or flushing; head is held until the arbiter grants it (deq_ready).
module dcache_data_read_req_queue #(
    parameter int DEPTH        = 4,
    parameter int ADDR_W       = dcache_rdq_pkg::ADDR_W,
    parameter int STARVE_LIMIT = dcache_rdq_pkg::DEFAULT_STARVE_LIMIT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [ADDR_W-1:0]          enq_bits_addr,
    input  logic                       enq_bits_valid_0,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [ADDR_W-1:0]          deq_bits_addr,
    output logic                       deq_bits_valid_0,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       starved
);

    import dcache_rdq_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Same layout as rdq_entry_t, but sized by this instance's ADDR_W.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              valid_0;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head_entry;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             enq_fire;
    logic             deq_fire;

    // Full blocks enqueue even when a dequeue frees a slot this cycle, keeping enq_ready off the grant path.
    assign enq_ready = (count != FULL_CNT) && !flush;
    assign deq_valid = (count != '0);
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;

    // Head payload is zeroed when empty so stale storage never shows on the arbiter port.
    assign head_entry       = mem[head];
    assign deq_bits_addr    = deq_valid ? head_entry.addr    : '0;
    assign deq_bits_valid_0 = deq_valid ? head_entry.valid_0 : 1'b0;

    // Payload storage: written at tail on accept, contents otherwise untouched.
    always_ff @(posedge clock) begin
        if (enq_fire) begin
            mem[tail] <= '{addr: enq_bits_addr, valid_0: enq_bits_valid_0};
        end
    end

    // Pointer and occupancy update; flush wins over any handshake (a grant during flush is absorbed by the clear).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + PTR_W'(1);
            end
            if (deq_fire) begin
                head <= head + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef DCACHE_RDQ_STARVE_WATCHDOG_EN
    dcache_rdq_starve_wdog #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_wdog (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .starved   (starved)
    );
`else
    // No watchdog: starved is constant low (the limit is always >= 1, so this folds to 0).
    assign starved = (STARVE_LIMIT < 0);
`endif

endmodule

// File: tb/tb_dcache_data_read_req_queue.sv
// Purpose: directed self-checking bench for dcache_data_read_req_queue.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: deq_ready driven directly to model arbiter grant/loss.
module tb_dcache_data_read_req_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 12;
    localparam int LIMIT  = 3;
`ifdef DCACHE_RDQ_STARVE_WATCHDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              enq_valid = 1'b0;
    logic              enq_ready;
    logic [ADDR_W-1:0] enq_bits_addr = '0;
    logic              enq_bits_valid_0 = 1'b0;
    logic              deq_valid;
    logic              deq_ready = 1'b0;
    logic [ADDR_W-1:0] deq_bits_addr;
    logic              deq_bits_valid_0;
    logic [2:0]        count;
    logic              starved;

    int n_checks = 0;
    int n_fail   = 0;

    dcache_data_read_req_queue #(
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .flush            (flush),
        .enq_valid        (enq_valid),
        .enq_ready        (enq_ready),
        .enq_bits_addr    (enq_bits_addr),
        .enq_bits_valid_0 (enq_bits_valid_0),
        .deq_valid        (deq_valid),
        .deq_ready        (deq_ready),
        .deq_bits_addr    (deq_bits_addr),
        .deq_bits_valid_0 (deq_bits_valid_0),
        .count            (count),
        .starved          (starved)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic enq_one(input logic [ADDR_W-1:0] a, input logic v0);
        enq_valid = 1'b1;
        enq_bits_addr = a;
        enq_bits_valid_0 = v0;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready: got %b expected 1", enq_ready); end
        n_checks++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_deq_valid: got %b expected 0", deq_valid); end
        n_checks++; if (deq_bits_addr !== 12'h000) begin n_fail++; $display("FAIL reset_deq_addr: got %0h expected 0", deq_bits_addr); end
        n_checks++; if (starved !== 1'b0) begin n_fail++; $display("FAIL reset_starved: got %b expected 0", starved); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        deq_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enq_one(12'(16 * (i + 1)), (i % 2) == 0);
            n_checks++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
        end
        n_checks++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL fill_enq_ready: got %b expected 0", enq_ready); end
        enq_one(12'h050, 1'b1);
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_fifth_rejected: got %0d expected 4", count); end
        n_checks++; if (deq_bits_addr !== 12'h010) begin n_fail++; $display("FAIL fill_head: got %0h expected 010", deq_bits_addr); end
    endtask

    task automatic test_drain();
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (deq_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, deq_valid); end
            n_checks++; if (deq_bits_addr !== 12'(16 * (i + 1))) begin n_fail++; $display("FAIL drain_addr[%0d]: got %0h expected %0h", i, deq_bits_addr, 16 * (i + 1)); end
            n_checks++; if (deq_bits_valid_0 !== ((i % 2) == 0)) begin n_fail++; $display("FAIL drain_v0[%0d]: got %b expected %b", i, deq_bits_valid_0, (i % 2) == 0); end
            tick();
        end
        n_checks++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty_valid: got %b expected 0", deq_valid); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_empty_count: got %0d expected 0", count); end
        n_checks++; if (deq_bits_addr !== 12'h000) begin n_fail++; $display("FAIL drain_empty_addr: got %0h expected 0", deq_bits_addr); end
        deq_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        enq_one(12'h100, 1'b1);
        enq_one(12'h101, 1'b0);
        for (int i = 0; i < 8; i++) begin
            enq_valid = 1'b1;
            enq_bits_addr = 12'(12'h102 + i);
            enq_bits_valid_0 = 1'b1;
            deq_ready = 1'b1;
            n_checks++; if (deq_bits_addr !== 12'(12'h100 + i)) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0h expected %0h", i, deq_bits_addr, 12'h100 + i); end
            tick();
            n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, count); end
        end
        enq_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (deq_bits_addr !== 12'(12'h108 + i)) begin n_fail++; $display("FAIL b2b_tail_addr[%0d]: got %0h expected %0h", i, deq_bits_addr, 12'h108 + i); end
            tick();
        end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_final_count: got %0d expected 0", count); end
        deq_ready = 1'b0;
    endtask

    task automatic test_full_deq();
        for (int i = 0; i < 4; i++) enq_one(12'(12'h200 + i), 1'b0);
        n_checks++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL fulldeq_enq_ready: got %b expected 0", enq_ready); end
        enq_valid = 1'b1;
        enq_bits_addr = 12'h2FF;
        deq_ready = 1'b1;
        tick();
        enq_valid = 1'b0;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL fulldeq_count: got %0d expected 3", count); end
        for (int i = 1; i < 4; i++) begin
            n_checks++; if (deq_bits_addr !== 12'(12'h200 + i)) begin n_fail++; $display("FAIL fulldeq_addr[%0d]: got %0h expected %0h", i, deq_bits_addr, 12'h200 + i); end
            tick();
        end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL fulldeq_rejected_entry: got %0d expected 0", count); end
        deq_ready = 1'b0;
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 3; i++) enq_one(12'(12'h300 + i), 1'b1);
        flush = 1'b1;
        enq_valid = 1'b1;
        enq_bits_addr = 12'h3AA;
        #1;
        n_checks++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL flush_enq_ready: got %b expected 0", enq_ready); end
        tick();
        flush = 1'b0;
        enq_valid = 1'b0;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
        n_checks++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL flush_deq_valid: got %b expected 0", deq_valid); end
        tick();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_dropped: got %0d expected 0", count); end
        enq_one(12'h310, 1'b1);
        enq_one(12'h311, 1'b0);
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL prereset_count: got %0d expected 2", count); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL areset_count: got %0d expected 0", count); end
        n_checks++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL areset_deq_valid: got %b expected 0", deq_valid); end
        n_checks++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL areset_enq_ready: got %b expected 1", enq_ready); end
        n_checks++; if (deq_bits_addr !== 12'h000) begin n_fail++; $display("FAIL areset_deq_addr: got %0h expected 0", deq_bits_addr); end
        n_checks++; if (starved !== 1'b0) begin n_fail++; $display("FAIL areset_starved: got %b expected 0", starved); end
        #1;
        reset = 1'b0;
        tick();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL postreset_count: got %0d expected 0", count); end
    endtask

    task automatic test_watchdog();
        deq_ready = 1'b0;
        enq_one(12'h400, 1'b1);
        n_checks++; if (starved !== 1'b0) begin n_fail++; $display("FAIL wdog_initial: got %b expected 0", starved); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++; if (starved !== (WDOG_ON && i == 3)) begin n_fail++; $display("FAIL wdog_lost[%0d]: got %b expected %b", i, starved, WDOG_ON && i == 3); end
        end
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        n_checks++; if (starved !== 1'b0) begin n_fail++; $display("FAIL wdog_after_grant: got %b expected 0", starved); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL wdog_count: got %0d expected 0", count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_full_deq();
        test_flush_reset();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
